// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and counter sizing for the serial adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t;
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// FullAdder: existing single-bit full adder cell
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder driving one FullAdder LSB first
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = cnt_width(WIDTH);
  sa_state_t state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0] cnt;
  logic carry, fa_s, fa_cout, last;
  FullAdder u_fa (
    .a(a_sr[0]),
    .b(b_sr[0]),
    .cin(carry),
    .s(fa_s),
    .cout(fa_cout)
  );
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  // accept operands in IDLE, add one bit per edge in SHIFT, pulse done for a cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr <= '0;
      b_sr <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else if (state == IDLE && start) begin
      state <= SHIFT;
      a_sr <= a;
      b_sr <= b;
      carry <= cin;
      cnt <= '0;
      sum <= '0;
    end else if (state == SHIFT) begin
      sum <= WIDTH'({fa_s, sum} >> 1);
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      carry <= fa_cout;
      cnt <= cnt + CW'(1);
      if (last) begin
        state <= DONE;
        cout <= fa_cout;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for WIDTH=8 and WIDTH=3 serial adders
module tb_serial_adder_ctrl;
  typedef struct {int res; int acc; int due;} exp_t;
  logic clk = 0, rst_n = 0;
  logic start8 = 0, cin8 = 0, busy8, done8, cout8;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic start3 = 0, cin3 = 0, busy3, done3, cout3;
  logic [2:0] a3 = 0, b3 = 0, sum3;
  int cyc = 0, free8 = 0, free3 = 0;
  int compared = 0, mismatched = 0;
  exp_t q8[$], q3[$];
  serial_adder_ctrl #(.WIDTH(8)) d8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder_ctrl #(.WIDTH(3)) d3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, act, exp);
    end
  endtask
  // a start at edge e is taken when the block is free; done follows edge e+W
  task automatic drive8(input logic st, input logic [7:0] x, input logic [7:0] y, input logic c);
    start8 = st; a8 = x; b8 = y; cin8 = c;
    if (st && rst_n && cyc >= free8) begin
      q8.push_back('{int'(x) + int'(y) + int'(c), cyc, cyc + 9});
      free8 = cyc + 10;
    end
    @(negedge clk);
  endtask
  task automatic drive3(input logic st, input logic [2:0] x, input logic [2:0] y, input logic c);
    start3 = st; a3 = x; b3 = y; cin3 = c;
    if (st && rst_n && cyc >= free3) begin
      q3.push_back('{int'(x) + int'(y) + int'(c), cyc, cyc + 4});
      free3 = cyc + 5;
    end
    @(negedge clk);
  endtask
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c);
    drive8(1, x, y, c);
    for (int i = 0; i < 11; i++) drive8(0, 8'h00, 8'h00, 0);
  endtask
  always @(negedge clk) if (rst_n) begin
    logic eb, ed;
    eb = q8.size() > 0 && cyc > q8[0].acc;
    ed = q8.size() > 0 && cyc == q8[0].due;
    chk("busy8", busy8, eb);
    chk("done8", done8, ed);
    if (ed) begin
      chk("sum8", sum8, q8[0].res & 8'hFF);
      chk("cout8", cout8, (q8[0].res >> 8) & 1);
      void'(q8.pop_front());
    end
  end
  always @(negedge clk) if (rst_n) begin
    logic eb, ed;
    eb = q3.size() > 0 && cyc > q3[0].acc;
    ed = q3.size() > 0 && cyc == q3[0].due;
    chk("busy3", busy3, eb);
    chk("done3", done3, ed);
    if (ed) begin
      chk("sum3", sum3, q3[0].res & 7);
      chk("cout3", cout3, (q3[0].res >> 3) & 1);
      void'(q3.pop_front());
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    chk("rst_sum3", sum3, 0);
    rst_n = 1;
    free8 = cyc;
    free3 = cyc;
    op8(8'h00, 8'h00, 0);
    op8(8'hFF, 8'h01, 0);
    op8(8'hA5, 8'h5A, 1);
    op8(8'd100, 8'd27, 0);
    for (int i = 0; i < 300; i++)
      drive8($urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom), 1'($urandom));
    for (int i = 0; i < 12; i++) drive8(0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 20; i++) drive8(1, 8'($urandom), 8'($urandom), 1'($urandom));
    for (int i = 0; i < 12; i++) drive8(0, 8'h00, 8'h00, 0);
    drive8(1, 8'h33, 8'h44, 1);
    for (int i = 0; i < 4; i++) drive8(0, 8'h00, 8'h00, 0);
    rst_n = 0;
    q8.delete();
    #1;
    chk("midrst_busy", busy8, 0);
    chk("midrst_done", done8, 0);
    chk("midrst_sum", sum8, 0);
    chk("midrst_cout", cout8, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    free8 = cyc;
    free3 = cyc;
    op8(8'h0F, 8'h01, 0);
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        for (int c = 0; c < 2; c++) begin
          drive3(1, 3'(x), 3'(y), 1'(c));
          for (int i = 0; i < 4; i++) drive3(0, 3'h0, 3'h0, 0);
        end
    for (int i = 0; i < 8; i++) drive3(0, 3'h0, 3'h0, 0);
    chk("q8_drained", q8.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
